// File: rtl/vec_mul_arbiter_if.sv
// Requester and response bundle for vec_mul_arbiter.
// The arbiter takes the slave side; requesters and the result consumer take the master side.
interface vec_mul_arbiter_if #(
    parameter int C     = 4,
    parameter int W_X   = 8,
    parameter int W_K   = 8,
    parameter int N_REQ = 4
);
    localparam int W_Y  = W_X + W_K + $clog2(C);
    localparam int W_ID = $clog2(N_REQ);

    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0]                 req_ready;
    logic [N_REQ-1:0][C-1:0][W_X-1:0] req_x;
    logic [N_REQ-1:0][C-1:0][W_K-1:0] req_k;
    logic                             resp_valid;
    logic                             resp_ready;
    logic [W_ID-1:0]                  resp_id;
    logic [W_Y-1:0]                   resp_y;

    modport master (
        output req_valid, req_x, req_k, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_y
    );

    modport slave (
        input  req_valid, req_x, req_k, resp_ready,
        output req_ready, resp_valid, resp_id, resp_y
    );
endinterface

// File: rtl/vec_mul_arbiter.sv
// Round-robin arbiter sharing one vec_mul PE among N_REQ requesters; requester IDs ride a tag pipe.
// Defining VEC_MUL_ARB_CHECK_EN adds o_tag_err, a sticky flag for PE valid vs. tag valid disagreement.
module vec_mul_arbiter #(
    parameter  int C       = 4,
    parameter  int W_X     = 8,
    parameter  int W_K     = 8,
    parameter  int N_REQ   = 4,
    localparam int W_Y     = W_X + W_K + $clog2(C),
    localparam int LATENCY = $clog2(C) + 1,
    localparam int W_ID    = $clog2(N_REQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    vec_mul_arbiter_if.slave      io_bus,
    output logic                  o_pe_enable,
    output logic [C-1:0][W_X-1:0] o_pe_x,
    output logic [C-1:0][W_K-1:0] o_pe_k,
    input  logic [W_Y-1:0]        i_pe_y,
    input  logic                  i_pe_valid
`ifdef VEC_MUL_ARB_CHECK_EN
    ,
    output logic                  o_tag_err
`endif
);

    logic [W_ID-1:0]    r_ptr;
    logic [LATENCY-1:0] r_tag_v;
    logic [W_ID-1:0]    r_tag_id [LATENCY];

    logic               w_resp_v;
    logic               w_stall;
    logic               w_pe_en;
    logic               w_hit;
    logic               w_grant;
    logic [W_ID-1:0]    w_gnt_id;
    logic [W_ID-1:0]    w_ptr_nxt;
    logic [W_ID:0]      w_idx;
    logic [N_REQ-1:0]   w_ready;

    // Outputs are forced to their idle values for as long as reset is held, not just after it.
    assign w_resp_v    = r_tag_v[LATENCY-1] & ~i_rst;
    assign w_stall     = w_resp_v & ~io_bus.resp_ready;
    assign w_pe_en     = ~w_stall;
    assign o_pe_enable = w_pe_en;

    // Walk from the highest offset down so the requester closest to r_ptr is the final winner.
    always_comb begin
        w_hit    = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_ptr} + (W_ID + 1)'(i);
            if (w_idx >= (W_ID + 1)'(N_REQ)) begin
                w_idx = w_idx - (W_ID + 1)'(N_REQ);
            end
            if (io_bus.req_valid[w_idx[W_ID-1:0]]) begin
                w_hit    = 1'b1;
                w_gnt_id = w_idx[W_ID-1:0];
            end
        end
    end

    assign w_grant   = w_hit & w_pe_en & ~i_rst;
    assign w_ptr_nxt = (w_gnt_id == W_ID'(N_REQ - 1)) ? '0 : w_gnt_id + W_ID'(1);

    always_comb begin
        w_ready = '0;
        if (w_grant) begin
            w_ready[w_gnt_id] = 1'b1;
        end
    end

    assign io_bus.req_ready  = w_ready;
    assign o_pe_x            = w_grant ? io_bus.req_x[w_gnt_id] : '0;
    assign o_pe_k            = w_grant ? io_bus.req_k[w_gnt_id] : '0;
    assign io_bus.resp_valid = w_resp_v;
    assign io_bus.resp_id    = i_rst ? '0 : r_tag_id[LATENCY-1];
    assign io_bus.resp_y     = i_pe_y;

    // Pointer and tags advance only with the PE so tags stay aligned to PE results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tag_id[i] <= '0;
            end
        end else if (w_pe_en) begin
            if (w_grant) begin
                r_ptr <= w_ptr_nxt;
            end
            r_tag_v[0]  <= w_grant;
            r_tag_id[0] <= w_gnt_id;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

`ifdef VEC_MUL_ARB_CHECK_EN
    logic r_tag_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_err <= 1'b0;
        end else if (w_pe_en && (i_pe_valid != r_tag_v[LATENCY-1])) begin
            r_tag_err <= 1'b1;
        end
    end

    assign o_tag_err = r_tag_err;
`else
    logic w_unused_pe_valid;
    assign w_unused_pe_valid = i_pe_valid;
`endif

endmodule
